// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit. Legality and alignment are checked
// at acceptance, one data-memory access runs with a timeout, and load data is
// aligned and extended for writeback.
//   clk, rst                     clock; asynchronous active-high reset
//   req_valid/req_ready          request handshake from the execute stage
//   is_store, mem_op, addr,
//   wdata                        the operation (funct3 encoding), address, store data
//   dmem_req/we/addr/wdata/be    data-memory request, held stable while waiting
//   dmem_ack, dmem_rdata         data-memory completion and read word
//   rsp_valid/rdata/misaligned/
//   rsp_fault                    one-cycle result; rsp_* values hold until the next result
//   stall                        pipeline hold (NOT req_ready)
module load_store_unit #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_store,
   input  logic [2:0]  mem_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_misaligned,
   output logic        rsp_fault,
   output logic        stall
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt, w_cnt_inc;
   logic          r_is_store;
   logic [2:0]    r_op;
   logic [1:0]    r_lane;
   logic          w_accept, w_illegal, w_misaligned, w_timeout;
   logic [3:0]    w_be;
   logic [31:0]   w_st_data, w_ld_data;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   assign req_ready    = (r_state == IDLE);
   assign stall        = ~req_ready;
   assign rsp_valid    = (r_state == RESP);
   assign w_accept     = req_valid && req_ready;
   assign w_illegal    = (mem_op == 3'b011) || (mem_op[2:1] == 2'b11) || (is_store && mem_op[2]);
   assign w_misaligned = (mem_op[1:0] == 2'b01 && addr[0]) || (mem_op[1:0] == 2'b10 && addr[1:0] != 2'b00);
   assign w_cnt_inc    = r_cnt + 1'b1;
   // The access has already spent MEM_TIMEOUT-1 cycles waiting; this is the last one.
   assign w_timeout    = (w_cnt_inc == CW'(MEM_TIMEOUT));
   assign w_be         = mem_op[1] ? 4'b1111 : mem_op[0] ? (4'b0011 << addr[1:0]) : (4'b0001 << addr[1:0]);
   assign w_st_data    = mem_op[1] ? wdata : mem_op[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
   assign w_byte       = dmem_rdata[{r_lane, 3'b000} +: 8];
   assign w_half       = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
   // r_op[2] selects zero extension (LBU/LHU).
   assign w_ld_data    = r_op[1] ? dmem_rdata :
                         r_op[0] ? {{16{~r_op[2] & w_half[15]}}, w_half} :
                                   {{24{~r_op[2] & w_byte[7]}}, w_byte};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? ((w_illegal || w_misaligned) ? RESP : WAIT) : IDLE;
         WAIT:    w_next = (dmem_ack || w_timeout) ? RESP : WAIT;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt          <= '0;
         r_is_store     <= 1'b0;
         r_op           <= 3'b000;
         r_lane         <= 2'b00;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_wdata     <= '0;
         dmem_be        <= 4'b0000;
         rsp_rdata      <= '0;
         rsp_misaligned <= 1'b0;
         rsp_fault      <= 1'b0;
      end else if (w_accept) begin
         r_is_store <= is_store;
         r_op       <= mem_op;
         r_lane     <= addr[1:0];
         r_cnt      <= '0;
         if (w_illegal || w_misaligned) begin
            rsp_fault      <= w_illegal;
            rsp_misaligned <= ~w_illegal;
            rsp_rdata      <= '0;
         end else begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_wdata <= w_st_data;
            dmem_be    <= is_store ? w_be : 4'b1111;
         end
      end else if (r_state == WAIT) begin
         if (dmem_ack) begin
            dmem_req       <= 1'b0;
            rsp_fault      <= 1'b0;
            rsp_misaligned <= 1'b0;
            rsp_rdata      <= r_is_store ? '0 : w_ld_data;
         end else if (w_timeout) begin
            dmem_req       <= 1'b0;
            rsp_fault      <= 1'b1;
            rsp_misaligned <= 1'b0;
            rsp_rdata      <= '0;
         end else begin
            r_cnt <= w_cnt_inc;
         end
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, corner sequences and random transactions against a reference model.
module tb_load_store_unit;
   localparam int T = 12;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, is_store = 1'b0, dmem_ack = 1'b0;
   logic [2:0]  mem_op = 3'b000;
   logic [31:0] addr = '0, wdata = '0, dmem_rdata = '0;
   logic        req_ready, dmem_req, dmem_we, rsp_valid, rsp_misaligned, rsp_fault, stall;
   logic [31:0] dmem_addr, dmem_wdata, rsp_rdata;
   logic [3:0]  dmem_be;
   int          n_cmp = 0, n_err = 0;

   typedef struct {
      logic        mis, flt;
      logic [31:0] rdata;
      int          reqc, lat;
      logic [31:0] daddr, dwd;
      logic [3:0]  be;
      logic        we;
   } exp_t;
   typedef struct {
      logic        st;
      logic [2:0]  op;
      logic [31:0] a, wd, rd;
      int          dly;
      exp_t        e;
   } vec_t;

   load_store_unit #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .is_store(is_store), .mem_op(mem_op), .addr(addr), .wdata(wdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault), .stall(stall)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Expected behaviour from the rules: size from funct3, alignment by modulo,
   // lane extraction by shifting, ack index dly (0 = first WAIT cycle, <0 = never).
   function automatic exp_t model(input logic st, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd, input int dly);
      exp_t        e;
      int          size;
      logic        ill;
      logic [31:0] v;
      ill    = (op == 3'd3) || (op >= 3'd6) || (st && op >= 3'd4);
      size   = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
      e.flt  = ill;
      e.mis  = !ill && ((int'(a[1:0]) % size) != 0);
      e.rdata = '0;
      e.reqc = 0;
      e.lat  = 1;
      e.we   = st;
      e.daddr = a - 32'(a[1:0]);
      e.be   = st ? 4'(((1 << size) - 1) << a[1:0]) : 4'hF;
      e.dwd  = (size == 1) ? 32'(wd[7:0]) * 32'h01010101 :
               (size == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
      if (!ill && !e.mis) begin
         if (dly >= 0 && dly < T) begin
            e.reqc = dly + 1;
            v = rd >> (8 * int'(a[1:0]));
            if (!st)
               e.rdata = (size == 4) ? rd :
                         (size == 2) ? (op[2] ? 32'(v[15:0]) : 32'($signed(v[15:0]))) :
                                       (op[2] ? 32'(v[7:0])  : 32'($signed(v[7:0])));
         end else begin
            e.reqc = T;
            e.flt  = 1'b1;
         end
         e.lat = e.reqc + 1;
      end
      return e;
   endfunction

   task automatic do_txn(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int dly, input exp_t e, input bit noise);
      int          lat = 0, reqc = 0;
      bit          seen = 0, stable = 1;
      logic [31:0] g_addr = 'x, g_wd = 'x, g_rdata = 'x;
      logic [3:0]  g_be = 'x;
      logic        g_we = 'x, g_mis = 'x, g_flt = 'x;
      @(negedge clk);
      dmem_ack = 1'b0;
      req_valid = 1'b1; is_store = st; mem_op = op; addr = a; wdata = wd;
      check("ready_idle", req_ready, 1);
      @(posedge clk);
      #1 req_valid = 1'b0; addr = $urandom; wdata = $urandom; mem_op = 3'($urandom);
      for (int c = 1; c <= T + 8 && !seen; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1; lat = c;
            g_rdata = rsp_rdata; g_mis = rsp_misaligned; g_flt = rsp_fault;
         end
         if (dmem_req) begin
            if (reqc == 0) begin
               g_addr = dmem_addr; g_wd = dmem_wdata; g_be = dmem_be; g_we = dmem_we;
            end else if (dmem_addr !== g_addr || dmem_wdata !== g_wd || dmem_be !== g_be || dmem_we !== g_we)
               stable = 0;
            dmem_ack   = (reqc == dly);
            dmem_rdata = (reqc == dly) ? rd : $urandom;
            reqc++;
         end else begin
            dmem_ack   = noise ? 1'($urandom) : 1'b0;
            dmem_rdata = $urandom;
         end
      end
      if (!seen) check("rsp_timeout", 0, 1);
      check("latency", lat, e.lat);
      check("req_cycles", reqc, e.reqc);
      check("misaligned", g_mis, e.mis);
      check("fault", g_flt, e.flt);
      check("rdata", g_rdata, e.rdata);
      if (e.reqc > 0) begin
         check("dmem_addr", g_addr, e.daddr);
         check("dmem_be", g_be, e.be);
         check("dmem_we", g_we, e.we);
         check("dmem_stable", stable, 1);
         if (st) check("dmem_wdata", g_wd, e.dwd);
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      check("valid_1cyc", rsp_valid, 0);
      check("rdata_hold", rsp_rdata, e.rdata);
      check("fault_hold", rsp_fault, e.flt);
   endtask

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 0, '{1'b0, 1'b0, 32'hFFFFFF80, 1, 2, 32'h1000, 32'h0, 4'hF, 1'b0}};
      tbl[1]  = '{1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'h0, 1, '{1'b0, 1'b0, 32'h0, 2, 3, 32'h2000, 32'hABCDABCD, 4'hC, 1'b1}};
      tbl[2]  = '{1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 0, '{1'b1, 1'b0, 32'h0, 0, 1, 32'h0, 32'h0, 4'h0, 1'b0}};
      tbl[3]  = '{1'b0, 3'b101, 32'h2, 32'h0, 32'h55667788, -1, '{1'b0, 1'b1, 32'h0, T, T + 1, 32'h0, 32'h0, 4'hF, 1'b0}};
      tbl[4]  = '{1'b0, 3'b100, 32'h1, 32'h0, 32'h1234F6AA, T - 1, '{1'b0, 1'b0, 32'hF6, T, T + 1, 32'h0, 32'h0, 4'hF, 1'b0}};
      tbl[5]  = '{1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, '{1'b0, 1'b1, 32'h0, 0, 1, 32'h0, 32'h0, 4'h0, 1'b0}};
      tbl[6]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 2, '{1'b0, 1'b0, 32'hFFFF8001, 3, 4, 32'h100, 32'h0, 4'hF, 1'b0}};
      tbl[7]  = '{1'b1, 3'b000, 32'h3, 32'hA5, 32'h0, 0, '{1'b0, 1'b0, 32'h0, 1, 2, 32'h0, 32'hA5A5A5A5, 4'h8, 1'b1}};
      tbl[8]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, '{1'b0, 1'b0, 32'h0, 1, 2, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1}};
      tbl[9]  = '{1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 0, '{1'b0, 1'b1, 32'h0, 0, 1, 32'h0, 32'h0, 4'h0, 1'b0}};
      tbl[10] = '{1'b1, 3'b001, 32'h1, 32'h1, 32'h0, 0, '{1'b1, 1'b0, 32'h0, 0, 1, 32'h0, 32'h0, 4'h0, 1'b0}};
      tbl[11] = '{1'b0, 3'b110, 32'h2, 32'h0, 32'h0, 0, '{1'b0, 1'b1, 32'h0, 0, 1, 32'h0, 32'h0, 4'h0, 1'b0}};
      tbl[12] = '{1'b0, 3'b001, 32'h0, 32'h0, 32'hFFFF1234, 0, '{1'b0, 1'b0, 32'h1234, 1, 2, 32'h0, 32'h0, 4'hF, 1'b0}};
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_stall", stall, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_fault", rsp_fault, 0);
      check("rst_mis", rsp_misaligned, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_be", dmem_be, 0);
      rst = 1'b0;
      // Directed table
      foreach (tbl[i]) do_txn(tbl[i].st, tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].dly, tbl[i].e, 1'b0);
      // req_valid held during WAIT: no re-acceptance, stall asserted
      @(negedge clk);
      req_valid = 1'b1; is_store = 1'b0; mem_op = 3'b010; addr = 32'h40;
      @(posedge clk);
      #1 addr = 32'h44;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check("hold_stall", stall, 1);
         check("hold_ready", req_ready, 0);
         check("hold_addr", dmem_addr, 32'h40);
         dmem_ack = (c == 3); dmem_rdata = 32'h11223344;
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, 32'h11223344);
      check("hold_resp_stall", stall, 1);
      addr = 32'h1;
      @(negedge clk);
      check("next_ready", req_ready, 1);
      check("next_stall", stall, 0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("next_mis", rsp_misaligned, 1);
      check("next_valid", rsp_valid, 1);
      check("next_dmem_req", dmem_req, 0);
      // Reset in the middle of WAIT
      @(negedge clk);
      req_valid = 1'b1; is_store = 1'b0; mem_op = 3'b010; addr = 32'h80;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_req_pre", dmem_req, 1);
      rst = 1'b1;
      #1;
      check("midrst_req", dmem_req, 0);
      check("midrst_ready", req_ready, 1);
      check("midrst_stall", stall, 0);
      dmem_ack = 1'b1;
      @(negedge clk);
      rst = 1'b0; dmem_ack = 1'b0;
      begin
         int n_rv = 0, n_dr = 0;
         repeat (T + 3) begin
            @(negedge clk);
            n_rv += int'(rsp_valid);
            n_dr += int'(dmem_req);
         end
         check("midrst_no_rsp", n_rv, 0);
         check("midrst_no_req", n_dr, 0);
      end
      do_txn(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 0, model(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 0), 1'b0);
      // Randomized transactions against the model
      for (int i = 0; i < 150; i++) begin
         logic        st = 1'($urandom);
         logic [2:0]  op = 3'($urandom);
         logic [31:0] a = $urandom, wd = $urandom, rd = $urandom;
         int          dly = (($urandom % 8) == 0) ? -1 : int'($urandom_range(0, T + 1));
         if ($urandom % 2) op[2] = 1'b0;
         do_txn(st, op, a, wd, rd, dly, model(st, op, a, wd, rd, dly), 1'b1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: the number of WAIT cycles without dmem_ack before the access is aborted.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  in  1  execute stage presents a memory operation.
REQ-005 SHALL have port req_ready  out  1  unit is idle and accepts a request this cycle.
REQ-006 SHALL have port is_store  in  1  1 = store, 0 = load.
REQ-007 SHALL have port mem_op  in  3  RV32I funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-008 SHALL have port addr  in  32  effective address (ALU Result, A+B).
REQ-009 SHALL have port wdata  in  32  store data (rs2).
REQ-010 SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_be out 4: the data-memory request.
REQ-011 SHALL have ports dmem_ack in 1 and dmem_rdata in 32: the data-memory completion and read word.
REQ-012 SHALL have ports rsp_valid out 1, rsp_rdata out 32, rsp_misaligned out 1, rsp_fault out 1: the result to the writeback stage.
REQ-013 SHALL have port stall  out  1  pipeline hold; equals NOT req_ready.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request when req_valid and req_ready are both 1, and register is_store, mem_op, addr and wdata at acceptance.
REQ-016 SHALL treat as illegal any mem_op in {011, 110, 111}, and any store with mem_op[2] = 1; on an illegal op: IDLE -> RESP, rsp_fault = 1, no dmem_req issued.
REQ-017 SHALL treat as misaligned a halfword op with addr[0] = 1 or a word op with addr[1:0] != 00; on a misaligned op: IDLE -> RESP, rsp_misaligned = 1, no dmem_req issued.
REQ-018 SHALL go IDLE -> WAIT for a legal aligned op, assert dmem_req registered from the first WAIT cycle, and drive dmem_addr = {addr[31:2], 2'b00} and dmem_we = is_store.
REQ-019 SHALL hold dmem_req and all dmem_* outputs stable in WAIT until dmem_ack is sampled 1, then deassert dmem_req in the next cycle and go to RESP.
REQ-020 SHALL form store data and byte enables as follows: SB: dmem_wdata = byte replicated 4x, dmem_be = 0001 << addr[1:0]; SH: halfword replicated 2x, dmem_be = 0011 << addr[1:0]; SW: dmem_be = 1111.
REQ-021 SHALL drive dmem_be = 1111 for loads.
REQ-022 SHALL, for loads, select the byte/halfword lane given by addr[1:0] from dmem_rdata captured on ack, then sign-extend (LB, LH) or zero-extend (LBU, LHU) it; LW passes the word through; stores return rsp_rdata = 0.
REQ-023 SHALL count WAIT cycles in a counter wide enough for MEM_TIMEOUT; when the count reaches MEM_TIMEOUT with no ack: deassert dmem_req, go to RESP, rsp_fault = 1.
REQ-024 SHALL give dmem_ack priority when dmem_ack arrives in the same cycle the timeout is reached: a normal completion with rsp_fault = 0.
REQ-025 SHALL ignore dmem_ack outside WAIT.
REQ-026 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; rsp_* outputs hold their values until the next RESP, and rsp_misaligned and rsp_fault are never both 1.
REQ-027 SHALL meet these latencies, counted from the acceptance edge: misaligned/illegal rsp_valid after 1 cycle; ack in the first WAIT cycle gives rsp_valid after 2 cycles; the earliest next acceptance is the cycle after RESP.

Reset
REQ-028 SHALL, while rst = 1, asynchronously force state IDLE, counter 0, and all outputs 0 except req_ready = 1 and stall = 0.
REQ-029 SHALL, on reset during WAIT, drop dmem_req immediately, issue no response, and discard the in-flight access.

Verification
REQ-030 SHALL cover: LB addr=0x1003, dmem_rdata=0x80AABBCC, ack in the first WAIT cycle -> rsp_rdata=0xFFFFFF80, rsp_valid 2 cycles after accept.
REQ-031 SHALL cover: SH addr=0x2002, wdata=0x1234ABCD -> dmem_addr=0x2000, dmem_wdata=0xABCDABCD, dmem_be=1100, dmem_we=1.
REQ-032 SHALL cover: LW addr=0x0006 -> rsp_misaligned=1 one cycle after accept, dmem_req never asserted.
REQ-033 SHALL cover: LHU addr=0x0002, ack never arrives -> dmem_req high exactly MEM_TIMEOUT cycles, then rsp_fault=1, rsp_valid one cycle.
REQ-034 SHALL cover: dmem_ack on the exact timeout cycle -> rsp_fault=0 with valid data; rst pulse mid-WAIT -> dmem_req=0 immediately, rsp_valid stays 0, and the next request completes normally.
REQ-035 SHALL cover: mem_op=011 load -> rsp_fault=1, no dmem_req; req_valid held during WAIT -> not accepted, stall=1.
